// File: rtl/datmem_arbiter.sv
// -----------------------------------------------------------------------------
// datmem_arbiter
//
// Arbitrates the byte-wide data memory between the CPU load/store path and the
// debug/loader port. A granted request becomes one 32-bit big-endian word
// transfer made of four byte beats (lowest address carries bits 31:24). The RAM
// is external: combinational read at o_mem_addr, written on the clock edge
// while o_mem_we is high.
//
// Configuration macro:
//   DATMEM_DBG_PRIORITY_EN  - when defined the debug port wins every
//                             simultaneous request; otherwise round-robin.
//
// Ports:
//   i_clk, i_reset                      clock, async active-high reset
//   i_cpu_req/we/addr/wdata             CPU request (held until o_cpu_ack)
//   o_cpu_rdata, o_cpu_ack              CPU read word and completion pulse
//   i_dbg_req/we/addr/wdata             debug request (held until o_dbg_ack)
//   o_dbg_rdata, o_dbg_ack              debug read word and completion pulse
//   o_mem_addr, o_mem_we, o_mem_wdata   byte RAM address / strobe / data
//   i_mem_rdata                         byte read from RAM at o_mem_addr
//   o_busy                              high while a transfer or ack is active
// -----------------------------------------------------------------------------
module datmem_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_ack,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [31:0]       i_dbg_wdata,
    output logic [31:0]       o_dbg_rdata,
    output logic              o_dbg_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_ACK
    } state_t;

    state_t            r_state;
    logic [1:0]        r_beat;
    logic              r_owner;       // 1 = debug port owns the transfer
    logic              r_last_grant;  // 1 = debug port was granted last
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [23:0]       r_wsh;         // remaining write bytes, next one on top
    logic [23:0]       r_cap;         // read bytes captured so far
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_dbg_rdata;
    logic              r_cpu_ack;
    logic              r_dbg_ack;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;
    logic              r_busy;

    logic              w_grant_dbg;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [ADDR_W-1:0] w_base;
    logic [1:0]        w_next_beat;
    logic [31:0]       w_rd_word;

`ifdef DATMEM_DBG_PRIORITY_EN
    assign w_grant_dbg = i_dbg_req;
`else
    // Debug wins only when the CPU is idle or the CPU had the last grant.
    assign w_grant_dbg = i_dbg_req & (~i_cpu_req | ~r_last_grant);
`endif

    assign w_sel_we    = w_grant_dbg ? i_dbg_we    : i_cpu_we;
    assign w_sel_addr  = w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
    assign w_sel_wdata = w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
    assign w_base      = w_sel_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign w_next_beat = r_beat + 2'd1;
    // Beat 3's byte is still on the bus at the final edge, so it is appended.
    assign w_rd_word   = {r_cap, i_mem_rdata};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_base       <= '0;
            r_wsh        <= '0;
            r_cap        <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req | i_dbg_req) begin
                        r_state      <= S_XFER;
                        r_busy       <= 1'b1;
                        r_owner      <= w_grant_dbg;
                        r_last_grant <= w_grant_dbg;
                        r_we         <= w_sel_we;
                        r_base       <= w_base;
                        r_beat       <= '0;
                        // Beat 0 bus values are set up here so the memory
                        // outputs are registered and valid for the whole beat.
                        r_mem_addr   <= w_base;
                        r_mem_we     <= w_sel_we;
                        r_mem_wdata  <= w_sel_we ? w_sel_wdata[31:24] : '0;
                        r_wsh        <= w_sel_we ? w_sel_wdata[23:0]  : '0;
                    end
                end
                S_XFER: begin
                    r_cap <= {r_cap[15:0], i_mem_rdata};
                    if (r_beat == 2'd3) begin
                        r_state     <= S_ACK;
                        r_mem_addr  <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                        if (r_owner) begin
                            r_dbg_ack <= 1'b1;
                            if (!r_we) r_dbg_rdata <= w_rd_word;
                        end else begin
                            r_cpu_ack <= 1'b1;
                            if (!r_we) r_cpu_rdata <= w_rd_word;
                        end
                    end else begin
                        r_beat      <= w_next_beat;
                        r_mem_addr  <= r_base | {{(ADDR_W-2){1'b0}}, w_next_beat};
                        r_mem_wdata <= r_wsh[23:16];
                        r_wsh       <= {r_wsh[15:0], 8'h00};
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_dbg_rdata = r_dbg_rdata;
    assign o_dbg_ack   = r_dbg_ack;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_datmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_datmem_arbiter
//
// Bench for datmem_arbiter: an external byte RAM, a transaction-level model
// (whole-word transfers on a six-cycle timeline), a per-cycle compare against
// that model, directed scenarios with literal expectations, and a randomized
// two-port traffic phase. Honours DATMEM_DBG_PRIORITY_EN in its expectations.
// -----------------------------------------------------------------------------
module tb_datmem_arbiter;

`ifdef DATMEM_DBG_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [4:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
    logic        cpu_ack, dbg_ack;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy;

    logic [7:0]  ram     [32];
    logic [7:0]  mdl_mem [32];

    int n_pass = 0;
    int n_chk  = 0;

    datmem_arbiter #(.ADDR_W(5)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_cpu_req  (cpu_req),
        .i_cpu_we   (cpu_we),
        .i_cpu_addr (cpu_addr),
        .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata),
        .o_cpu_ack  (cpu_ack),
        .i_dbg_req  (dbg_req),
        .i_dbg_we   (dbg_we),
        .i_dbg_addr (dbg_addr),
        .i_dbg_wdata(dbg_wdata),
        .o_dbg_rdata(dbg_rdata),
        .o_dbg_ack  (dbg_ack),
        .o_mem_addr (mem_addr),
        .o_mem_we   (mem_we),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    // External RAM: combinational read, clocked write.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mdl_word(input logic [4:0] base);
        return {mdl_mem[base], mdl_mem[base + 5'd1], mdl_mem[base + 5'd2], mdl_mem[base + 5'd3]};
    endfunction

    // ---------------- reference model ----------------
    // m_phase: 0 idle, 1..4 = byte beat (phase-1), 5 = ack cycle.
    int          m_phase;
    bit          m_owner, m_we, m_last;
    logic [4:0]  m_base;
    logic [31:0] m_word, m_cpu_rd, m_dbg_rd;

    always @(posedge clk or posedge reset) begin : model
        bit         g;
        logic [4:0] a;
        logic [31:0] sh;
        if (reset) begin
            m_phase  = 0;
            m_last   = 1'b1;
            m_cpu_rd = '0;
            m_dbg_rd = '0;
        end else if (m_phase == 0) begin
            if (cpu_req || dbg_req) begin
                if (cpu_req && dbg_req) g = PRIO ? 1'b1 : !m_last;
                else                    g = dbg_req;
                m_owner = g;
                m_last  = g;
                m_we    = g ? dbg_we : cpu_we;
                a       = g ? dbg_addr : cpu_addr;
                m_base  = {a[4:2], 2'b00};
                m_word  = m_we ? (g ? dbg_wdata : cpu_wdata) : mdl_word(m_base);
                m_phase = 1;
            end
        end else if (m_phase <= 4) begin
            if (m_we) begin
                sh = m_word >> (8 * (4 - m_phase));
                mdl_mem[m_base + 5'(m_phase - 1)] = sh[7:0];
            end
            if (m_phase == 4 && !m_we) begin
                if (m_owner) m_dbg_rd = m_word;
                else         m_cpu_rd = m_word;
            end
            m_phase++;
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit          x;
        logic [31:0] sh;
        x  = (m_phase >= 1 && m_phase <= 4);
        sh = x ? (m_word >> (8 * (4 - m_phase))) : 32'd0;
        chk("busy",      {31'd0, busy},      {31'd0, m_phase != 0});
        chk("mem_addr",  {27'd0, mem_addr},  x ? {27'd0, m_base + 5'(m_phase - 1)} : 32'd0);
        chk("mem_we",    {31'd0, mem_we},    {31'd0, x && m_we});
        chk("mem_wdata", {24'd0, mem_wdata}, (x && m_we) ? {24'd0, sh[7:0]} : 32'd0);
        chk("cpu_ack",   {31'd0, cpu_ack},   {31'd0, m_phase == 5 && !m_owner});
        chk("dbg_ack",   {31'd0, dbg_ack},   {31'd0, m_phase == 5 && m_owner});
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("dbg_rdata", dbg_rdata, m_dbg_rd);
    end

    // ---------------- directed helpers ----------------
    int         d_lat, d_we, d_busy;
    logic [4:0] d_addr [4];

    task automatic xact(input bit dbg, input bit we, input logic [4:0] addr, input logic [31:0] wd);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        d_lat = 0; d_we = 0; d_busy = 0;
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        for (int n = 1; n <= 20 && !done; n++) begin
            @(posedge clk); #1;
            if (mem_we) d_we++;
            if (busy)   d_busy++;
            if (n <= 4) d_addr[n-1] = mem_addr;
            if (dbg ? dbg_ack : cpu_ack) begin
                d_lat = n;
                done  = 1'b1;
                if (dbg) dbg_req = 0; else cpu_req = 0;
            end
        end
        if (!done) begin
            chk("xact_ack_timeout", 32'd0, 32'd1);
            cpu_req = 0; dbg_req = 0;
        end
    endtask

    initial begin : stim
        int         ack_t [4];
        bit         ack_o [4];
        int         k;
        bit         dbg_seen;
        bit         issuing;
        reset = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 32; i++) begin ram[i] = 8'h00; mdl_mem[i] = 8'h00; end
        ram[4] = 8'h12; ram[5] = 8'h34; ram[6] = 8'h56; ram[7] = 8'h78;
        mdl_mem[4] = 8'h12; mdl_mem[5] = 8'h34; mdl_mem[6] = 8'h56; mdl_mem[7] = 8'h78;
        repeat (3) @(posedge clk);
        #2 reset = 0;

        // Reset state
        chk("rst_busy",      {31'd0, busy},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata,       32'd0);
        chk("rst_dbg_rdata", dbg_rdata,       32'd0);

        // CPU read of 0x04
        xact(1'b0, 1'b0, 5'h04, 32'h0);
        chk("rd_latency",    d_lat,     32'd5);
        chk("rd_cpu_rdata",  cpu_rdata, 32'h12345678);
        chk("rd_no_we",      d_we,      32'd0);
        chk("rd_dbg_rdata",  dbg_rdata, 32'd0);

        // CPU write 0xDEADBEEF to 0x08
        xact(1'b0, 1'b1, 5'h08, 32'hDEADBEEF);
        chk("wr_ram8",       {24'd0, ram[8]},  32'hDE);
        chk("wr_ram9",       {24'd0, ram[9]},  32'hAD);
        chk("wr_ram10",      {24'd0, ram[10]}, 32'hBE);
        chk("wr_ram11",      {24'd0, ram[11]}, 32'hEF);
        chk("wr_we_cycles",  d_we,   32'd4);
        chk("wr_busy_cycles", d_busy, 32'd5);

        // Unaligned debug read at 0x0B
        xact(1'b1, 1'b0, 5'h0B, 32'h0);
        for (int i = 0; i < 4; i++) chk("ua_mem_addr", {27'd0, d_addr[i]}, 32'(8 + i));
        chk("ua_dbg_rdata",  dbg_rdata, 32'hDEADBEEF);
        chk("ua_cpu_rdata",  cpu_rdata, 32'h12345678);

        // Simultaneous, continuously held requests
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h04;
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'h08;
        k = 0;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(posedge clk); #1;
            if (cpu_ack || dbg_ack) begin
                ack_t[k] = n;
                ack_o[k] = dbg_ack;
                k++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        chk("arb_ack_count", k, 32'd4);
        for (int i = 0; i < k; i++) begin
            chk("arb_owner", {31'd0, ack_o[i]}, PRIO ? 32'd1 : 32'(i % 2));
            chk("arb_time",  ack_t[i], 32'(5 + 6 * i));
        end
        @(posedge clk); #1;

        // Reset during beat 2 of a CPU write to 0x10
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'h10; cpu_wdata = 32'hAABBCCDD;
        repeat (3) begin @(posedge clk); #1; end
        chk("mr_pre_we",    {31'd0, mem_we},   32'd1);
        chk("mr_pre_wdata", {24'd0, mem_wdata}, 32'hCC);
        reset = 1;
        #1;
        chk("mr_we",      {31'd0, mem_we},  32'd0);
        chk("mr_busy",    {31'd0, busy},    32'd0);
        chk("mr_ack",     {31'd0, cpu_ack}, 32'd0);
        chk("mr_addr",    {27'd0, mem_addr}, 32'd0);
        cpu_req = 0;
        @(posedge clk); #2;
        reset = 0;
        chk("mr_ram16", {24'd0, ram[16]}, 32'hAA);
        chk("mr_ram17", {24'd0, ram[17]}, 32'hBB);
        chk("mr_ram18", {24'd0, ram[18]}, 32'h00);
        chk("mr_ram19", {24'd0, ram[19]}, 32'h00);
        chk("mr_cpu_rdata", cpu_rdata, 32'd0);

        // CPU read of a word while a debug write to it is in progress
        @(posedge clk); #1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 5'h14; dbg_wdata = 32'h11223344;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h16;
        dbg_seen = 1'b0;
        k = 0;
        for (int n = 1; n <= 30 && k == 0; n++) begin
            @(posedge clk); #1;
            if (dbg_ack) begin dbg_seen = 1'b1; dbg_req = 0; end
            if (cpu_ack) begin
                chk("raw_order", {31'd0, dbg_seen}, 32'd1);
                chk("raw_cpu_rdata", cpu_rdata, 32'h11223344);
                cpu_req = 0;
                k = 1;
            end
        end
        chk("raw_cpu_acked", k, 32'd1);
        cpu_req = 0; dbg_req = 0;

        // Randomized two-port traffic
        issuing = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (n >= 2900) issuing = 1'b0;
            if (cpu_ack) cpu_req = 0;
            else if (!cpu_req && issuing && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 5'($urandom_range(0, 31)); cpu_wdata = $urandom;
            end
            if (dbg_ack) dbg_req = 0;
            else if (!dbg_req && issuing && $urandom_range(0, 2) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 5'($urandom_range(0, 31)); dbg_wdata = $urandom;
            end
        end
        chk("rand_drained", {30'd0, cpu_req, dbg_req}, 32'd0);
        cpu_req = 0; dbg_req = 0;
        repeat (8) @(posedge clk);

        for (int i = 0; i < 32; i++) chk("final_ram", {24'd0, ram[i]}, {24'd0, mdl_mem[i]});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/datmem_arbiter.md
# datmem_arbiter

Arbitrates and sequences access to the byte-wide data memory (32 entries × 8 bits) between the processor's load/store path and a debug/loader port. Each granted request is a 32-bit big-endian word transfer serialized into four byte beats. Byte at the lowest address is bits 31:24, matching instruction fetch ordering. The arbiter sits between both requesters and the memory array; the array itself is an external combinational-read, clocked-write byte RAM.

## Interface
- ADDR_W, 5, byte address width (memory depth = 2**ADDR_W = 32)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  32  write word; stable while cpu_req
- cpu_rdata  out  32  read word; valid in cpu_ack cycle, held until next CPU grant
- cpu_ack  out  1  single-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: identical semantics for the debug port
- mem_addr  out  ADDR_W  byte address to RAM
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  combinational read byte from RAM at mem_addr
- busy  out  1  high in XFER and ACK states

## Operation
- States: IDLE, XFER, ACK. Reset → IDLE, beat counter 0, last_grant = DBG, both rdata = 0, all outputs 0.
- IDLE: if any req high, latch owner, we, word base {addr[ADDR_W-1:2],2'b00}, wdata; go XFER, beat = 0.
- Arbitration when both request in IDLE: round-robin. Grant the port not in last_grant; update last_grant on each grant. After reset the CPU wins first.
- XFER: mem_addr = base + beat. On writes mem_we = 1 and mem_wdata = byte (3-beat) of latched word, i.e. beat 0 → [31:24]. On reads, mem_rdata is shifted into the capture register at the end of each beat. After beat 3 → ACK.
- End of beat 3 on reads: owner's rdata register loads the assembled word. The other port's rdata is unchanged.
- ACK: owner's ack = 1 for exactly one cycle. Then → IDLE.
- A request still high in the IDLE cycle after ACK is a new request; requesters drop req in their ack cycle.
- Requests arriving during XFER/ACK wait; they are not lost as long as req is held.
- Outside XFER: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Address arithmetic is modulo 2**ADDR_W. Base is word-aligned, so no wrap occurs within a transfer.

## Timing
- Request high in IDLE cycle 0 → beats in cycles 1–4 → ack in cycle 5 → IDLE in cycle 6.
- Back-to-back throughput is 6 cycles per word.
- mem_we is high for exactly 4 consecutive cycles per write and never for reads.
- Reset asserted mid-transfer:
  - All outputs go to reset values immediately, asynchronously. mem_we drops in the same cycle.
  - No ack is issued.
  - Bytes whose write edge already occurred stay written; remaining bytes are unchanged.
- After reset deasserts, the first edge evaluates IDLE normally.

## Configuration
- DATMEM_DBG_PRIORITY_EN defined: the debug port wins every simultaneous request in IDLE, regardless of last_grant. A continuously requesting debug port can starve the CPU.
- Not defined: round-robin as above.

## Test plan
- RAM[4..7] = 12,34,56,78; CPU read addr 0x04 → cpu_ack in cycle 5, cpu_rdata = 0x12345678, mem_we never high, dbg_rdata stays 0.
- CPU write addr 0x08, data 0xDEADBEEF → RAM[8..11] = DE,AD,BE,EF; mem_we high exactly 4 cycles; busy high for 5 cycles.
- Unaligned dbg read addr 0x0B → mem_addr sequence 08,09,0A,0B; dbg_rdata = RAM[8..11] word.
- Both ports request simultaneously, held continuously (macro off) → grant order CPU, DBG, CPU, DBG; acks spaced 6 cycles apart. Macro on → DBG receives every grant until dbg_req drops.
- Reset asserted during beat 2 of a CPU write of 0xAABBCCDD to 0x10 (RAM zero) → mem_we low immediately, no cpu_ack, RAM[0x10..0x13] = AA,BB,00,00, state IDLE, busy = 0.
- CPU read while a debug write to the same word is in progress → CPU receives the newly written word after the debug ack.
